user_locked_read_port: RTL and testbench

//  Read-side responder for the user-locked register. Serves read requests
//    for the register value over a req/valid/ack handshake.

---
 rtl/user_locked_read_port.sv | 130 +++++++++++++
 tb/tb_user_locked_read_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_locked_read_port.sv
// ============================================================================
// Module      : user_locked_read_port
// Description : Read responder for the user-locked register; owner-only data,
//               consecutive-denial counting and lockout until owner unlock.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module user_locked_read_port #(
  parameter int         WIDTH    = 8,
  parameter logic [1:0] OWNER_ID = 2'h2,
  parameter int         MAX_VIOL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] reg_value,
  input  logic             rd_req,
  input  logic [1:0]       usr_id,
  input  logic             unlock,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_err,
  input  logic             rd_ack,
  output logic [2:0]       viol_cnt,
  output logic             locked_out
);

  localparam logic [2:0] C_MAX_VIOL = 3'(MAX_VIOL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_RESP    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_cap_id;
  logic [WIDTH-1:0] r_cap_val;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_err;
  logic [2:0]       r_viol;
  logic             r_locked;

  logic w_owner;
  logic w_unlock_ok;
  logic w_ack_done;

  assign w_owner     = (r_cap_id == OWNER_ID);
  assign w_unlock_ok = unlock && (usr_id == OWNER_ID);
  assign w_ack_done  = r_rd_valid && rd_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (rd_req) w_next = ST_CHECK;
      ST_CHECK:   w_next = ST_RESP;
      // The counter was already updated in CHECK, so it reflects this response.
      ST_RESP:    if (w_ack_done) w_next = (r_viol == C_MAX_VIOL) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (w_unlock_ok) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_id   <= 2'd0;
      r_cap_val  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
      r_viol     <= 3'd0;
      r_locked   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rd_req) begin
            r_cap_id  <= usr_id;
            r_cap_val <= reg_value;
          end
        end
        ST_CHECK: begin
          if (w_owner) begin
            r_rd_data <= r_cap_val;
            r_rd_err  <= 1'b0;
            r_viol    <= 3'd0;
          end else begin
            r_rd_data <= '0;
            r_rd_err  <= 1'b1;
            r_viol    <= (r_viol >= C_MAX_VIOL) ? C_MAX_VIOL : r_viol + 3'd1;
          end
        end
        ST_RESP: begin
          // First RESP cycle raises valid; an ack only counts once valid is up.
          if (!r_rd_valid) begin
            r_rd_valid <= 1'b1;
          end else if (rd_ack) begin
            r_rd_valid <= 1'b0;
            if (r_viol == C_MAX_VIOL) r_locked <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (w_unlock_ok) begin
            r_viol   <= 3'd0;
            r_locked <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_ready   = (r_state == ST_IDLE);
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign rd_err     = r_rd_err;
  assign viol_cnt   = r_viol;
  assign locked_out = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_user_locked_read_port.sv
// ============================================================================
// Module      : tb_user_locked_read_port
// Description : Directed plus randomized bench with a transaction-level model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_user_locked_read_port;

  localparam int         WIDTH = 8;
  localparam logic [1:0] OWNER = 2'h2;
  localparam int         MAXV  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] reg_value = '0;
  logic             rd_req = 1'b0;
  logic [1:0]       usr_id = 2'd0;
  logic             unlock = 1'b0;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_err;
  logic             rd_ack = 1'b0;
  logic [2:0]       viol_cnt;
  logic             locked_out;

  user_locked_read_port #(.WIDTH(WIDTH), .OWNER_ID(OWNER), .MAX_VIOL(MAXV)) dut (
    .clk(clk), .rst_n(rst_n), .reg_value(reg_value), .rd_req(rd_req),
    .usr_id(usr_id), .unlock(unlock), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .rd_ack(rd_ack), .viol_cnt(viol_cnt),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age is -1 when idle, else cycles elapsed since the request was taken.
  int         m_age = -1;
  bit         m_locked = 1'b0;
  int         m_vcnt = 0;
  logic [7:0] m_cap = '0;
  logic [1:0] m_id = '0;
  logic [7:0] m_data = '0;
  bit         m_err = 1'b0;
  bit         m_valid = 1'b0;

  task automatic model_reset();
    m_age = -1; m_locked = 1'b0; m_vcnt = 0;
    m_data = '0; m_err = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    if (m_locked) begin
      if (unlock && usr_id == OWNER) begin
        m_locked = 1'b0;
        m_vcnt = 0;
      end
    end else if (m_age < 0) begin
      if (rd_req) begin
        m_cap = reg_value; m_id = usr_id; m_age = 0;
      end
    end else if (m_age == 0) begin
      if (m_id == OWNER) begin
        m_data = m_cap; m_err = 1'b0; m_vcnt = 0;
      end else begin
        m_data = '0; m_err = 1'b1;
        m_vcnt = (m_vcnt + 1 > MAXV) ? MAXV : m_vcnt + 1;
      end
      m_age = 1;
    end else if (m_age == 1) begin
      m_valid = 1'b1; m_age = 2;
    end else if (rd_ack) begin
      m_valid = 1'b0; m_age = -1;
      if (m_vcnt == MAXV) m_locked = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  always @(negedge clk) begin
    check("ready",  32'(rd_ready),   32'(!m_locked && m_age < 0));
    check("valid",  32'(rd_valid),   32'(m_valid));
    check("data",   32'(rd_data),    32'(m_data));
    check("err",    32'(rd_err),     32'(m_err));
    check("viol",   32'(viol_cnt),   32'(m_vcnt));
    check("locked", 32'(locked_out), 32'(m_locked));
  end

  task automatic read_txn(input logic [1:0] id, input logic [7:0] val, input int hold,
                          input logic [7:0] e_data, input bit e_err, input int e_vcnt);
    reg_value = val; usr_id = id; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    check("lat_early_valid", 32'(rd_valid), 32'd0);
    tick();
    check("lat_valid", 32'(rd_valid), 32'd1);
    check("txn_data",  32'(rd_data),  32'(e_data));
    check("txn_err",   32'(rd_err),   32'(e_err));
    check("txn_viol",  32'(viol_cnt), 32'(e_vcnt));
    for (int i = 0; i < hold; i++) begin
      reg_value = 8'($urandom);
      tick();
      check("hold_valid", 32'(rd_valid), 32'd1);
      check("hold_data",  32'(rd_data),  32'(e_data));
    end
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("ack_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    check("rst_valid",  32'(rd_valid),   32'd0);
    check("rst_data",   32'(rd_data),    32'd0);
    check("rst_err",    32'(rd_err),     32'd0);
    check("rst_viol",   32'(viol_cnt),   32'd0);
    check("rst_locked", 32'(locked_out), 32'd0);
    check("rst_ready",  32'(rd_ready),   32'd1);
    rst_n = 1'b1;
    tick();

    read_txn(2'd2, 8'hA5, 0, 8'hA5, 1'b0, 0);
    read_txn(2'd1, 8'h3C, 0, 8'h00, 1'b1, 1);
    read_txn(2'd2, 8'h77, 0, 8'h77, 1'b0, 0);

    read_txn(2'd0, 8'h11, 0, 8'h00, 1'b1, 1);
    read_txn(2'd0, 8'h22, 0, 8'h00, 1'b1, 2);
    read_txn(2'd0, 8'h33, 0, 8'h00, 1'b1, 3);
    check("lock_set",   32'(locked_out), 32'd1);
    check("lock_ready", 32'(rd_ready),   32'd0);
    rd_req = 1'b1; usr_id = 2'd2;
    repeat (3) tick();
    rd_req = 1'b0;
    check("lock_noresp", 32'(rd_valid),   32'd0);
    check("lock_still",  32'(locked_out), 32'd1);
    unlock = 1'b1; usr_id = 2'd3;
    tick();
    unlock = 1'b0;
    check("badunlock_locked", 32'(locked_out), 32'd1);
    check("badunlock_viol",   32'(viol_cnt),   32'd3);
    unlock = 1'b1; usr_id = 2'd2;
    tick();
    unlock = 1'b0;
    check("unlock_locked", 32'(locked_out), 32'd0);
    check("unlock_ready",  32'(rd_ready),   32'd1);
    check("unlock_viol",   32'(viol_cnt),   32'd0);

    read_txn(2'd2, 8'h5A, 5, 8'h5A, 1'b0, 0);

    // Request held high through CHECK and RESP: only one response may appear.
    reg_value = 8'hC3; usr_id = 2'd2; rd_req = 1'b1;
    repeat (3) tick();
    check("busy_valid", 32'(rd_valid), 32'd1);
    check("busy_data",  32'(rd_data),  32'hC3);
    rd_req = 1'b0; rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    repeat (4) tick();
    check("busy_one_resp", 32'(rd_valid), 32'd0);
    check("busy_ready",    32'(rd_ready), 32'd1);

    reg_value = 8'h3C; usr_id = 2'd1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (2) tick();
    check("rstresp_valid", 32'(rd_valid), 32'd1);
    check("rstresp_viol",  32'(viol_cnt), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rstresp_valid0", 32'(rd_valid), 32'd0);
    check("rstresp_data0",  32'(rd_data),  32'd0);
    check("rstresp_err0",   32'(rd_err),   32'd0);
    check("rstresp_viol0",  32'(viol_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstresp_ready", 32'(rd_ready), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rd_req    = 1'($urandom);
      usr_id    = 2'($urandom);
      reg_value = 8'($urandom);
      rd_ack    = 1'($urandom);
      unlock    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    rd_req = 1'b0; rd_ack = 1'b0; unlock = 1'b0; rst_n = 1'b1;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
